gpio_axis: RTL and testbench
============================

# gpio_axis

Samples a bank of board inputs (switches/buttons) and transmits their value as a fixed-length AXI-stream byte packet. It is the transmit-side counterpart of the stream-to-LED block. The GPIO value occupies bytes BYTE_START onward, MSB byte first, so a stream-to-LED block with matching parameters reproduces the same value on its LEDs. It sits on the master side of a byte stream, typically feeding a UART/Ethernet TX path.

## Interface
- BYTE_START, 31: zero-based index of the first packet byte carrying GPIO data.
- GPIO_WIDTH, 16: input width. Must be a multiple of AXI_WIDTH.
- AXI_WIDTH, 8: stream data width.
- PACKET_LEN, 64: bytes per packet. Requires BYTE_START + GPIO_WIDTH/AXI_WIDTH <= PACKET_LEN.
- FILL_BYTE, 8'h00: value of every non-GPIO byte.
- HEARTBEAT_CYCLES, 1000000: idle cycles before a forced resend. Used only when the heartbeat macro is defined.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous, active-high reset.
- gpio_in, input, GPIO_WIDTH: asynchronous board inputs.
- m_axis_data, output, AXI_WIDTH: stream data.
- m_axis_valid, output, 1: stream valid.
- m_axis_last, output, 1: high on the final byte of a packet.
- m_axis_ready, input, 1: downstream ready.

## Operation
- **Input synchronizer:** two flops, gpio_in -> s1 -> s2. It is always present.
- **Registers:**
  - snapshot: the value being sent.
  - last_sent: the value of the most recent packet.
  - startup: a flag, set by reset.
  - byte_cnt: counts 0..PACKET_LEN-1.
- **FSM, two states:**
  - IDLE: valid=0. A trigger occurs when startup=1, or s2 != last_sent, or a heartbeat expires (macro only). On a trigger: snapshot<=s2, last_sent<=s2, startup<=0, byte_cnt<=0, valid<=1, go to SEND.
  - SEND: valid=1.
    - On each valid&ready, byte_cnt increments.
    - On the handshake with byte_cnt==PACKET_LEN-1: valid<=0 and go to IDLE.
- **Byte mapping,** for byte index i:
  - i in [BYTE_START, BYTE_START+GPIO_WIDTH/AXI_WIDTH-1]: data = snapshot[GPIO_WIDTH-1-(i-BYTE_START)*AXI_WIDTH -: AXI_WIDTH].
  - Otherwise: data = FILL_BYTE.
- **last:** last = (byte_cnt==PACKET_LEN-1) while valid.
- **Input changes during SEND** do not alter the packet in flight (snapshot is frozen). If s2 differs from last_sent on return to IDLE, a new packet starts on the next edge. Intermediate values that revert before then are not sent.
- **Reset values:** m_axis_valid=0, m_axis_last=0, m_axis_data=FILL_BYTE, byte_cnt=0, last_sent=0, startup=1, state IDLE.
- **Reset mid-packet:** the packet is truncated and last is not sent. After reset, a startup packet is always sent.

## Timing
- **Change-to-valid latency:** a gpio_in change captured at edge k gives s1 at k, s2 at k+1, and m_axis_valid high after edge k+2. That is 3 edges, when IDLE and no reset.
- **After reset:** rst deasserted at edge r gives valid high after edge r+1 (startup packet).
- **Handshake:**
  - data, last and valid are held stable while valid & !ready.
  - valid is never dropped mid-packet except by reset.
  - No bubbles are inserted by the master. With ready held high, the packet takes exactly PACKET_LEN consecutive cycles.
- **Between packets:** at least one cycle with valid=0, the IDLE cycle.
- **Throughput:** the minimum period per packet is PACKET_LEN+1 cycles.
- **Simultaneous events:** a trigger while in SEND is deferred, never dropped, if the value persists. Reset has priority over everything.
- **Widths:**
  - byte_cnt is $clog2(PACKET_LEN) bits and never wraps past PACKET_LEN-1.
  - The heartbeat counter is 32 bits and saturates at HEARTBEAT_CYCLES-1.

## Configuration
- **Macro:** GPIO_AXIS_HEARTBEAT_EN.
- **Defined:**
  - A 32-bit idle counter clears on every packet start and increments each IDLE cycle.
  - Reaching HEARTBEAT_CYCLES-1 in IDLE is a trigger, so the unchanged value is resent.
  - The counter holds at 0 while in SEND.
- **Undefined:** the counter logic is absent. Packets are sent only at startup and on input change.

## Test plan
- **Startup packet:** reset 4 cycles with gpio_in=16'h0000, ready=1. Expect one 64-byte packet, valid rising after the edge following reset release. All bytes are 8'h00, last only on byte 63, then valid stays low.
- **Change and mapping:** gpio_in=16'hA55A. Expect valid after 3 edges. Byte 31=8'hA5, byte 32=8'h5A, other bytes FILL_BYTE, last on byte 63. Looping into the stream-to-LED block gives led_out=16'hA55A.
- **Backpressure:** toggle ready pseudo-randomly. data and last are held while ready=0, exactly 64 handshakes occur, and the payload matches the snapshot.
- **Change mid-packet:** change gpio_in to 16'h1234 at byte 10. The current packet is unchanged. After last, exactly one idle cycle, then a packet carrying 8'h12, 8'h34.
- **Reset mid-packet:** assert rst at byte 20. valid and last are 0 after the edge. After release, a fresh startup packet begins at byte 0.
- **Heartbeat:** with GPIO_AXIS_HEARTBEAT_EN and HEARTBEAT_CYCLES=100, static input. Packets repeat with exactly 100 IDLE cycles between them. Without the macro, no second packet appears within 10000 cycles.

Source files
------------

// File: rtl/gpio_axis_if.sv
// gpio_axis_if: byte-stream handshake bundle between a stream master and slave.
//
// Parameters:
//   AXI_WIDTH - width of the data bus.
// Signals:
//   data  - stream payload, driven by the master.
//   valid - master has a beat to offer.
//   last  - marks the final beat of a packet.
//   ready - slave accepts the beat this cycle.
// Modports:
//   master - drives data/valid/last, samples ready.
//   slave  - samples data/valid/last, drives ready.

interface gpio_axis_if #(
    parameter int AXI_WIDTH = 8
) ();

    logic [AXI_WIDTH-1:0] data;
    logic                 valid;
    logic                 last;
    logic                 ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/gpio_axis.sv
// gpio_axis: samples a bank of board inputs and sends their value as a
// fixed-length byte packet on a stream master. The GPIO value sits at byte
// BYTE_START onward, most significant byte first; every other byte is FILL_BYTE.
// A packet is sent once after reset and again whenever the synchronised input
// differs from the value last sent.
//
// Parameters:
//   BYTE_START       - index of the first packet byte carrying GPIO data.
//   GPIO_WIDTH       - input width, a multiple of AXI_WIDTH.
//   AXI_WIDTH        - stream data width.
//   PACKET_LEN       - bytes per packet.
//   FILL_BYTE        - value of every non-GPIO byte.
//   HEARTBEAT_CYCLES - idle cycles before a forced resend (heartbeat build only).
// Ports:
//   clk     - single clock.
//   rst     - synchronous, active-high reset.
//   gpio_in - asynchronous board inputs.
//   m_axis  - stream master (data, valid, last out; ready in).
// Build option:
//   GPIO_AXIS_HEARTBEAT_EN - when defined, an unchanged value is resent after
//   HEARTBEAT_CYCLES idle cycles.

module gpio_axis #(
    parameter int                   BYTE_START       = 31,
    parameter int                   GPIO_WIDTH       = 16,
    parameter int                   AXI_WIDTH        = 8,
    parameter int                   PACKET_LEN       = 64,
    parameter logic [AXI_WIDTH-1:0] FILL_BYTE        = 8'h00,
    parameter int                   HEARTBEAT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    gpio_axis_if.master           m_axis
);

    localparam int GPIO_BYTES = GPIO_WIDTH / AXI_WIDTH;
    localparam int CNT_W      = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_LEN - 1);

    if ((GPIO_WIDTH % AXI_WIDTH) != 0 ||
        (BYTE_START + GPIO_BYTES) > PACKET_LEN ||
        HEARTBEAT_CYCLES < 1) begin : g_param_err
        $error("gpio_axis: inconsistent parameters");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Packet byte for index idx: GPIO slice inside the payload window, fill elsewhere.
    function automatic logic [AXI_WIDTH-1:0] byte_at(
        input logic [CNT_W-1:0]      idx,
        input logic [GPIO_WIDTH-1:0] snap
    );
        logic [AXI_WIDTH-1:0] b;
        int                   i;
        b = FILL_BYTE;
        i = int'(idx);
        for (int k = 0; k < GPIO_BYTES; k++) begin
            if (i == BYTE_START + k) begin
                b = snap[GPIO_WIDTH-1-k*AXI_WIDTH -: AXI_WIDTH];
            end
        end
        return b;
    endfunction

    logic [GPIO_WIDTH-1:0] gpio_s1;
    logic [GPIO_WIDTH-1:0] gpio_s2;
    logic [GPIO_WIDTH-1:0] snapshot;
    logic [GPIO_WIDTH-1:0] last_sent;
    logic                  startup;
    logic [CNT_W-1:0]      byte_cnt;
    state_t                state;
    state_t                state_nxt;
    logic                  trigger;
    logic                  hb_expired;
    logic [AXI_WIDTH-1:0]  data_c;
    logic                  valid_c;
    logic                  last_c;

    // Input synchronizer: gpio_in -> s1 -> s2
    always_ff @(posedge clk) begin
        gpio_s1 <= gpio_in;
        gpio_s2 <= gpio_s1;
    end

`ifdef GPIO_AXIS_HEARTBEAT_EN
    localparam logic [31:0] HB_MAX = 32'(HEARTBEAT_CYCLES - 1);

    logic [31:0] hb_cnt;

    // Idle counter: zero while sending and on each packet start, saturating in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
        end else if (state != IDLE || trigger) begin
            hb_cnt <= '0;
        end else if (hb_cnt != HB_MAX) begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end

    assign hb_expired = (hb_cnt == HB_MAX);
`else
    assign hb_expired = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream outputs; data is combinational off byte_cnt so
    // it stays stable for as long as ready is low.
    always_comb begin
        state_nxt = state;
        trigger   = 1'b0;
        valid_c   = 1'b0;
        last_c    = 1'b0;
        data_c    = FILL_BYTE;
        case (state)
            IDLE: begin
                trigger = startup || (gpio_s2 != last_sent) || hb_expired;
                if (trigger) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                valid_c = 1'b1;
                data_c  = byte_at(byte_cnt, snapshot);
                last_c  = (byte_cnt == LAST_IDX);
                if (m_axis.ready && last_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packet control: startup flag, value last sent, byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            startup   <= 1'b1;
            last_sent <= '0;
            byte_cnt  <= '0;
        end else if (trigger) begin
            startup   <= 1'b0;
            last_sent <= gpio_s2;
            byte_cnt  <= '0;
        end else if (valid_c && m_axis.ready) begin
            byte_cnt <= last_c ? '0 : byte_cnt + CNT_W'(1);
        end
    end

    // Snapshot frozen for the whole packet; only the payload bytes read it.
    always_ff @(posedge clk) begin
        if (trigger) begin
            snapshot <= gpio_s2;
        end
    end

    assign m_axis.data  = data_c;
    assign m_axis.valid = valid_c;
    assign m_axis.last  = last_c;

endmodule

// File: tb/tb_gpio_axis.sv
// tb_gpio_axis: randomized scoreboard bench for gpio_axis. Each stimulus step
// pushes the packet it should produce; a monitor pops and compares on every
// handshake and also checks hold-under-backpressure and the inter-packet gap.

module tb_gpio_axis;

    localparam int         BS   = 31;
    localparam int         GW   = 16;
    localparam int         AW   = 8;
    localparam int         PL   = 64;
    localparam int         NB   = GW / AW;
    localparam logic [7:0] FILL = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [GW-1:0] gpio_in = '0;

    gpio_axis_if #(.AXI_WIDTH(AW)) axis ();

    gpio_axis #(
        .BYTE_START      (BS),
        .GPIO_WIDTH      (GW),
        .AXI_WIDTH       (AW),
        .PACKET_LEN      (PL),
        .FILL_BYTE       (FILL),
        .HEARTBEAT_CYCLES(100)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .gpio_in(gpio_in),
        .m_axis (axis.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec    = 0;
    int    n_err    = 0;
    int    hs_count = 0;
    bit    bp_mode  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packet: fill everywhere, value bytes MSB first from BS.
    task automatic push_packet(input logic [GW-1:0] v);
        beat_t b;
        for (int i = 0; i < PL; i++) begin
            if (i >= BS && i < BS + NB)
                b.data = 8'((v >> ((NB - 1 - (i - BS)) * AW)) & 16'hFF);
            else
                b.data = FILL;
            b.last = (i == PL - 1);
            exp_q.push_back(b);
        end
    endtask

    // Ready driver
    initial begin
        axis.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis.ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall = 1'b0;
    bit         prev_end   = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_end   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(axis.valid), 32'd1);
                check("hold_data", 32'(axis.data), 32'(prev_data));
                check("hold_last", 32'(axis.last), 32'(prev_last));
            end
            if (prev_end) check("gap_after_last", 32'(axis.valid), 32'd0);
            prev_end = 1'b0;
            if (axis.valid && axis.ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h last %0b with nothing expected",
                             axis.data, axis.last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(axis.data), 32'(e.data));
                    check("beat_last", 32'(axis.last), 32'(e.last));
                end
                prev_end = axis.last;
            end
            prev_stall = axis.valid && !axis.ready;
            prev_data  = axis.data;
            prev_last  = axis.last;
        end
    end

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(exp_q.size() == 0 && !axis.valid) && t < budget);
        if (t >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: %0d beats still expected after %0d cycles", exp_q.size(), t);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int t = 0;
        while (hs_count < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (hs_count < target) begin
            n_vec++;
            n_err++;
            $display("FAIL hs_timeout: got %0d handshakes required %0d", hs_count, target);
        end
    endtask

    initial begin
        logic [GW-1:0] v;
        int            base;
        int            cnt;

        // Reset and startup packet
        rst     = 1'b1;
        gpio_in = '0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_valid", 32'(axis.valid), 32'd0);
        check("reset_last", 32'(axis.last), 32'd0);
        check("reset_data", 32'(axis.data), 32'(FILL));
        push_packet('0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("startup_latency", 32'(axis.valid), 32'd1);
        wait_idle(500);

        // Change and mapping, three-edge latency
        gpio_in = 16'hA55A;
        push_packet(16'hA55A);
        @(posedge clk);
        #1;
        check("chg_edge1", 32'(axis.valid), 32'd0);
        @(posedge clk);
        #1;
        check("chg_edge2", 32'(axis.valid), 32'd0);
        @(posedge clk);
        #1;
        check("chg_edge3", 32'(axis.valid), 32'd1);
        wait_idle(500);

        // Backpressure
        bp_mode = 1'b1;
        v       = 16'($urandom);
        if (v == gpio_in) v = v ^ 16'h1;
        base = hs_count;
        push_packet(v);
        gpio_in = v;
        wait_idle(5000);
        bp_mode = 1'b0;
        check("bp_handshakes", 32'(hs_count - base), 32'(PL));

        // Change mid-packet: packet in flight unchanged, then exactly one idle cycle
        gpio_in = 16'h0F0F;
        push_packet(16'h0F0F);
        base = hs_count;
        wait_hs(base + 10, 200);
        gpio_in = 16'h1234;
        push_packet(16'h1234);
        wait_hs(base + PL, 500);
        @(negedge clk);
        #1;
        check("one_idle", 32'(axis.valid), 32'd0);
        @(negedge clk);
        #1;
        check("restart_after_idle", 32'(axis.valid), 32'd1);
        wait_idle(500);

        // Reset mid-packet
        v = 16'($urandom);
        if (v == gpio_in) v = v ^ 16'h8000;
        gpio_in = v;
        push_packet(v);
        base = hs_count;
        wait_hs(base + 20, 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 32'(axis.valid), 32'd0);
        check("rst_mid_last", 32'(axis.last), 32'd0);
        exp_q.delete();
        push_packet(v);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_restart_valid", 32'(axis.valid), 32'd1);
        check("rst_restart_byte0", 32'(axis.data), 32'(FILL));
        wait_idle(500);

        // Randomized values with random backpressure
        repeat (8) begin
            v = 16'($urandom);
            if (v == gpio_in) v = v ^ 16'h0001;
            bp_mode = 1'($urandom_range(0, 1));
            push_packet(v);
            gpio_in = v;
            wait_idle(5000);
            bp_mode = 1'b0;
        end

`ifdef GPIO_AXIS_HEARTBEAT_EN
        // Heartbeat: unchanged value resent after 100 idle cycles
        push_packet(gpio_in);
        cnt = 0;
        while (!axis.valid && cnt < 1000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("heartbeat_gap", 32'(cnt), 32'd100);
        wait_idle(500);
`else
        // No heartbeat: static input must stay quiet
        cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            #1;
            if (axis.valid) cnt++;
        end
        check("no_heartbeat", 32'(cnt), 32'd0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
